// File: rtl/spi_instr_fetch_pkg.sv
// Shared types and constants for the SPI instruction fetch stage.
//   fetch_state_t : fetch FSM encoding
//   fetch_buf_t   : one-entry instruction buffer payload
//   SPI_CMD_READ, CMD/ADDR/DATA bit counts, word-to-byte address helper
package spi_instr_fetch_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned CMD_BITS     = 8;
    localparam int unsigned ADDR_BITS    = 24;
    localparam int unsigned DATA_BITS    = 16;
    localparam int unsigned XFER_BITS    = CMD_BITS + ADDR_BITS + DATA_BITS;
    localparam int unsigned BIT_CNT_W    = 6;
    localparam int unsigned PC_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } fetch_state_t;

    typedef struct packed {
        logic            vld;
        logic [PC_W-1:0] pc;
        logic [15:0]     data;
    } fetch_buf_t;

    // 16-bit word address -> 24-bit byte address; bit 17 and up are always zero.
    function automatic logic [ADDR_BITS-1:0] word_to_byte_addr(input logic [PC_W-1:0] wa);
        return {7'b0, wa, 1'b0};
    endfunction

endpackage

// File: rtl/spi_instr_fetch_bit_clock.sv
// SPI mode-0 bit clock generator.
//   clk, rst : clock and synchronous active-high reset
//   en       : transaction active; sck idles low and counters clear while low
//   sck      : SPI clock, half period CLK_DIV clk cycles
//   rise_c   : sck rises on the coming edge (sample point)
//   fall_c   : sck falls on the coming edge (shift point)
// The first enabled cycle is a chip-select setup cycle before the divider starts.
module spi_instr_fetch_bit_clock #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             armed;
    logic             tick_c;

    assign tick_c = en & armed & (div_cnt == DIV_LAST);
    assign rise_c = tick_c & ~sck;
    assign fall_c = tick_c &  sck;

    // Divider and sck toggle.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            armed   <= 1'b0;
            sck     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed) begin
                if (tick_c) begin
                    div_cnt <= '0;
                    sck     <= ~sck;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_instr_fetch.sv
// Instruction fetch stage for risc16: reads the 16-bit word at pc from SPI
// flash/SRAM (READ command, mode 0) into a one-entry buffer.
//   clk, rst      : clock and synchronous active-high reset
//   fetch_req     : core wants the instruction at pc
//   pc            : word address
//   instr         : buffered instruction word
//   instr_valid   : buffer holds the word at pc (combinational hit)
//   spi_cs_n/sck/mosi/miso : SPI master interface
module spi_instr_fetch
    import spi_instr_fetch_pkg::*;
#(
    parameter logic [7:0]  CMD_READ = SPI_CMD_READ,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic [PC_W-1:0] pc,
    output logic [15:0]     instr,
    output logic            instr_valid,
    output logic            spi_cs_n,
    output logic            spi_sck,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    localparam int unsigned          GAP_W     = $clog2(CS_IDLE + 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(CS_IDLE);
    localparam logic [BIT_CNT_W-1:0] CMD_LAST  = BIT_CNT_W'(CMD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(CMD_BITS + ADDR_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] XFER_LAST = BIT_CNT_W'(XFER_BITS - 1);
    localparam int unsigned          TX_W      = CMD_BITS + ADDR_BITS - 1;

    fetch_state_t          state, state_d;
    logic [PC_W-1:0]       req_pc, req_pc_d;
    logic [TX_W-1:0]       tx_sr, tx_d;
    logic [DATA_BITS-1:0]  rx_sr, rx_d;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt, gap_d;
    fetch_buf_t            fbuf, fbuf_d;
    logic                  cs_n_d, mosi_d;
    logic                  hit_c, clk_en_c, rise_c, fall_c;

    assign hit_c       = fbuf.vld && (fbuf.pc == pc) && (state == ST_IDLE);
    assign instr_valid = hit_c;
    assign instr       = fbuf.data;
    assign clk_en_c    = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);

    spi_instr_fetch_bit_clock #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_clock (
        .clk    (clk),
        .rst    (rst),
        .en     (clk_en_c),
        .sck    (spi_sck),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_pc   <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            fbuf     <= '0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            state    <= state_d;
            req_pc   <= req_pc_d;
            tx_sr    <= tx_d;
            rx_sr    <= rx_d;
            bit_cnt  <= bit_cnt_d;
            gap_cnt  <= gap_d;
            fbuf     <= fbuf_d;
            spi_cs_n <= cs_n_d;
            spi_mosi <= mosi_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        req_pc_d  = req_pc;
        tx_d      = tx_sr;
        rx_d      = rx_sr;
        bit_cnt_d = bit_cnt;
        gap_d     = gap_cnt;
        fbuf_d    = fbuf;
        cs_n_d    = spi_cs_n;
        mosi_d    = spi_mosi;

        case (state)
            ST_IDLE: begin
                if (fetch_req && !hit_c) begin
                    state_d    = ST_CMD;
                    req_pc_d   = pc;
                    tx_d       = {CMD_READ[6:0], word_to_byte_addr(pc)};
                    mosi_d     = CMD_READ[7];
                    rx_d       = '0;
                    bit_cnt_d  = '0;
                    fbuf_d.vld = 1'b0;
                    cs_n_d     = 1'b0;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                if (rise_c && (state == ST_DATA)) begin
                    rx_d = {rx_sr[DATA_BITS-2:0], spi_miso};
                end
                if (fall_c) begin
                    if (bit_cnt == XFER_LAST) begin
                        fbuf_d.vld  = 1'b1;
                        fbuf_d.pc   = req_pc;
                        fbuf_d.data = rx_sr;
                        cs_n_d      = 1'b1;
                        mosi_d      = 1'b0;
                        gap_d       = '0;
                        state_d     = ST_GAP;
                    end else begin
                        // Next outgoing bit goes out on the same edge sck falls.
                        bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                        mosi_d    = tx_sr[TX_W-1];
                        tx_d      = {tx_sr[TX_W-2:0], 1'b0};
                        if (bit_cnt == CMD_LAST) begin
                            state_d = ST_ADDR;
                        end else if (bit_cnt == ADDR_LAST) begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            // cs_n stays high through the whole gap; the final gap cycle
            // covers the hand-over from the completed read to the buffer hit.
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
